apb_fifo_slave: RTL

APB responder exposing a word-wide FIFO through four memory-mapped registers, with programmable wait states and registered PREADY/PRDATA. It sits on one PSELx/PRDATAx/PREADYx slot of the existing APB master, for example region 0x1000_2xxx, and is the counterpart to its initiator. Software pushes words by writing a data register, pops them by reading another, and polls status.

---
 rtl/apb_fifo_pkg.sv | 15 +
 rtl/apb_fifo_slave_if.sv | 13 +
 rtl/apb_fifo_mem.sv | 45 ++++
 rtl/apb_fifo_slave.sv | 95 +++++++++
 4 files changed

// File: rtl/apb_fifo_pkg.sv
// apb_fifo_pkg: shared FSM state, register offsets and bit positions for the APB FIFO responder
package apb_fifo_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam logic [1:0] STATUS = 2'd0;
  localparam logic [1:0] WDATA  = 2'd1;
  localparam logic [1:0] RDATA  = 2'd2;
  localparam logic [1:0] CTRL   = 2'd3;
  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVF   = 2;
  localparam int ST_UNF   = 3;
  localparam int ST_CNT   = 8;
  localparam int CTRL_IE  = 0;
  localparam int CTRL_CLR = 1;
endpackage

// File: rtl/apb_fifo_slave_if.sv
// apb_fifo_slave_if: APB completer-side bus bundle with master/slave views
interface apb_fifo_slave_if;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PWRITE;
  logic        PENABLE;
  logic        PSEL;
  logic        PREADY;
  logic        PSLVERR;
  modport master (output PADDR, PWDATA, PWRITE, PENABLE, PSEL, input PRDATA, PREADY, PSLVERR);
  modport slave  (input PADDR, PWDATA, PWRITE, PENABLE, PSEL, output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/apb_fifo_mem.sv
// apb_fifo_mem: DEPTH x 32 circular buffer; push/pop ignored when full/empty, clr wins over both
module apb_fifo_mem #(
  parameter int DEPTH = 8
) (
  input  logic                     PCLK,
  input  logic                     PRESETn,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clr,
  input  logic [31:0]              wdata,
  output logic [31:0]              head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic          do_push, do_pop;
  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign head    = mem[rp];
  assign do_push = push && !full && !clr;
  assign do_pop  = pop && !empty && !clr;
  // storage needs no reset: only entries below count are ever observed
  always_ff @(posedge PCLK) begin
    if (do_push) mem[wp] <= wdata;
  end
  // pointers wrap naturally at DEPTH since DEPTH is a power of two
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (clr) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/apb_fifo_slave.sv
// apb_fifo_slave: APB responder with FIFO registers and wait states; APB_FIFO_SLVERR_EN enables PSLVERR
module apb_fifo_slave
  import apb_fifo_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  apb_fifo_slave_if.slave     apb,
  output logic                irq
);
  localparam int W = $clog2(DEPTH) + 1;
  state_t        state, state_nx;
  logic [1:0]    addr_q;
  logic          write_q;
  logic [31:0]   wdata_q;
  logic [3:0]    wait_q;
  logic          ie, ovf, unf;
  logic [W-1:0]  count;
  logic          full, empty;
  logic [31:0]   head, status, rdata_c;
  logic          fire, push, pop, clr, err_c;
  assign status = {{(24-W){1'b0}}, count, 4'b0, unf, ovf, full, empty};
  assign fire   = state == WAIT && apb.PSEL && wait_q == '0 && apb.PENABLE;
  apb_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .PCLK(PCLK), .PRESETn(PRESETn), .push(push), .pop(pop), .clr(clr),
    .wdata(wdata_q), .head(head), .count(count), .full(full), .empty(empty)
  );
  // state register
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= IDLE;
    else state <= state_nx;
  end
  // next state: setup starts a transfer, dropped PSEL aborts it, completion lasts one cycle
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = apb.PSEL && !apb.PENABLE ? WAIT : IDLE;
      WAIT:    state_nx = !apb.PSEL ? IDLE : fire ? RESP : WAIT;
      default: state_nx = IDLE;
    endcase
  end
  // decode the latched transfer into FIFO strobes, read data and error
  always_comb begin
    push    = fire && write_q && addr_q == WDATA;
    pop     = fire && !write_q && addr_q == RDATA;
    clr     = fire && write_q && addr_q == CTRL && wdata_q[CTRL_CLR];
    rdata_c = write_q ? '0 : addr_q == STATUS ? status : addr_q == RDATA ? (empty ? '0 : head) :
              addr_q == CTRL ? {31'b0, ie} : '0;
`ifdef APB_FIFO_SLVERR_EN
    err_c   = fire && ((push && full) || (pop && empty) ||
              (write_q && (addr_q == STATUS || addr_q == RDATA)) || (!write_q && addr_q == WDATA));
`else
    err_c   = 1'b0;
`endif
  end
  // transfer capture, wait countdown, registered response, stickies, IE and irq
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      addr_q      <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      wait_q      <= '0;
      apb.PREADY  <= 1'b0;
      apb.PRDATA  <= '0;
      apb.PSLVERR <= 1'b0;
      ovf         <= 1'b0;
      unf         <= 1'b0;
      ie          <= 1'b0;
      irq         <= 1'b0;
    end else begin
      if (state == IDLE && apb.PSEL && !apb.PENABLE) begin
        addr_q  <= apb.PADDR[3:2];
        write_q <= apb.PWRITE;
        wdata_q <= apb.PWDATA;
        wait_q  <= 4'(WAIT_CYCLES);
      end else if (state == WAIT && apb.PSEL && wait_q != '0) begin
        wait_q <= wait_q - 1'b1;
      end
      apb.PREADY  <= fire;
      apb.PRDATA  <= fire ? rdata_c : '0;
      apb.PSLVERR <= err_c;
      if (clr) begin
        ovf <= 1'b0;
        unf <= 1'b0;
      end else begin
        if (push && full) ovf <= 1'b1;
        if (pop && empty) unf <= 1'b1;
      end
      if (fire && write_q && addr_q == CTRL) ie <= wdata_q[CTRL_IE];
      irq <= ie && !empty;
    end
  end
endmodule
